// File: rtl/controle_pkg.sv
// controle_pkg: shared definitions for the Horner-scheme sequencer.
//   state_t   FSM state encoding (3 bits)
//   SEL_*     accumulator source select codes driven on sel_acc
//   idx_w_f   width of the degree / coefficient-index fields for a given MAX_DEG
package controle_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_X   = 3'd1,
    INIT_ACC = 3'd2,
    MUL      = 3'd3,
    ADD      = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] SEL_COEF = 2'd0;
  localparam logic [1:0] SEL_MUL  = 2'd1;
  localparam logic [1:0] SEL_ADD  = 2'd2;

  // Index fields must hold 0..max_deg, and are never narrower than 1 bit.
  function automatic int idx_w_f(input int max_deg);
    int w;
    w = $clog2(max_deg + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/contador_idx.sv
// contador_idx: loadable down-counter for the Horner coefficient index.
//   clock       system clock, rising edge
//   reset       synchronous, active-low clear
//   load        load load_value (has priority over dec)
//   load_value  value to load
//   dec         decrement by one; saturates at zero
//   count       current count
//   zero        count == 0
module contador_idx #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controle_horner.sv
// controle_horner: sequencer for a Horner-scheme polynomial datapath,
// y = a_d*x^d + ... + a_1*x + a_0, degree chosen per operation.
//   clock     system clock, rising edge
//   reset     synchronous, active-low
//   start     request an evaluation (taken when ready=1)
//   degree    polynomial degree, sampled with start
//   ack       consumer takes the result (meaningful while valid=1)
//   ready     can accept start this cycle
//   valid     result present in the datapath accumulator
//   err       requested degree exceeded MAX_DEG (qualified by valid)
//   load_x    load enable for datapath X register
//   load_acc  load enable for the accumulator
//   sel_acc   accumulator source: COEF / MUL / ADD
//   coef_idx  coefficient index presented to the datapath
//
// state    | meaning
// IDLE     | waiting for start
// LOAD_X   | capture x into the datapath
// INIT_ACC | acc <= a[d]
// MUL      | acc <= acc * x
// ADD      | acc <= acc + a[idx]
// DONE     | result valid, waiting for ack
module controle_horner
  import controle_pkg::*;
#(
  parameter  int MAX_DEG = 7,
  localparam int IDX_W   = idx_w_f(MAX_DEG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] degree,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic             err,
  output logic             load_x,
  output logic             load_acc,
  output logic [1:0]       sel_acc,
  output logic [IDX_W-1:0] coef_idx
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] d_reg;
  logic [IDX_W-1:0] idx;
  logic             idx_zero;
  logic             accept;
  logic             deg_bad;
  logic             cnt_load;
  logic             cnt_dec;

  // Widened so the check stays meaningful when IDX_W can only encode legal degrees.
  assign deg_bad = (32'(degree) > 32'(MAX_DEG));

  contador_idx #(.W(IDX_W)) u_idx (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (d_reg - IDX_ONE),
    .dec        (cnt_dec),
    .count      (idx),
    .zero       (idx_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      d_reg <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        d_reg <= degree;
        err   <= deg_bad;
      end else if (state == DONE && ack) begin
        err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    load_x   = 1'b0;
    load_acc = 1'b0;
    sel_acc  = SEL_COEF;
    coef_idx = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    valid    = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
      end
      LOAD_X: begin
        load_x  = 1'b1;
        state_n = INIT_ACC;
      end
      INIT_ACC: begin
        load_acc = 1'b1;
        sel_acc  = SEL_COEF;
        coef_idx = d_reg;
        cnt_load = (d_reg != '0);
        state_n  = (d_reg == '0) ? DONE : MUL;
      end
      MUL: begin
        load_acc = 1'b1;
        sel_acc  = SEL_MUL;
        state_n  = ADD;
      end
      ADD: begin
        load_acc = 1'b1;
        sel_acc  = SEL_ADD;
        coef_idx = idx;
        cnt_dec  = !idx_zero;
        state_n  = idx_zero ? DONE : MUL;
      end
      DONE: begin
        valid = 1'b1;
        ready = ack;
        if (ack) begin
          accept  = start;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Back-to-back accept from DONE skips IDLE entirely.
    if (accept) begin
      state_n = deg_bad ? DONE : LOAD_X;
    end
  end

endmodule

// File: tb/tb_controle_horner.sv
module tb_controle_horner;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       start, ack, ready, valid, err, load_x, load_acc;
  logic [1:0] sel_acc;
  logic [2:0] degree, coef_idx;

  logic       start5, ack5, ready5, valid5, err5, load_x5, load_acc5;
  logic [1:0] sel_acc5;
  logic [2:0] degree5, coef_idx5;

  controle_horner #(.MAX_DEG(7)) dut (
    .clock(clock), .reset(reset), .start(start), .degree(degree), .ack(ack),
    .ready(ready), .valid(valid), .err(err), .load_x(load_x), .load_acc(load_acc),
    .sel_acc(sel_acc), .coef_idx(coef_idx)
  );

  controle_horner #(.MAX_DEG(5)) dut5 (
    .clock(clock), .reset(reset), .start(start5), .degree(degree5), .ack(ack5),
    .ready(ready5), .valid(valid5), .err(err5), .load_x(load_x5), .load_acc(load_acc5),
    .sel_acc(sel_acc5), .coef_idx(coef_idx5)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard datapath driven by the controller outputs.
  int unsigned coef [8];
  int unsigned xin, xr, acc;
  int nx = 0, nacc = 0, viol = 0, nx5 = 0, nacc5 = 0;
  int seqq[$];

  always @(posedge clock) begin
    if (load_x) xr <= xin;
    if (load_acc) begin
      case (sel_acc)
        2'd0: acc <= coef[coef_idx];
        2'd1: acc <= acc * xr;
        2'd2: acc <= acc + coef[coef_idx];
        default: ;
      endcase
      nacc <= nacc + 1;
      seqq.push_back(int'(sel_acc) * 16 + int'(coef_idx));
    end
    if (load_x) nx <= nx + 1;
    if (!load_acc && coef_idx != 3'd0) viol <= viol + 1;
    if (sel_acc == 2'd3 || (load_x && load_acc)) viol <= viol + 1;
    if (load_x5) nx5 <= nx5 + 1;
    if (load_acc5) nacc5 <= nacc5 + 1;
  end

  int unsigned exp_res;
  int base_nx, base_nacc, base_seq;
  bit rand_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input int d);
    int unsigned p;
    if (rand_en) begin
      for (int i = 0; i < 8; i++) coef[i] = $urandom_range(0, 15);
      xin = $urandom_range(0, 15);
    end
    exp_res = 0;
    p = 1;
    for (int i = 0; i <= d; i++) begin
      exp_res = exp_res + coef[i] * p;
      p = p * xin;
    end
    base_nx = nx;
    base_nacc = nacc;
    base_seq = seqq.size();
    start = 1'b1;
    degree = 3'(d);
    #1 chk("ready_at_start", ready, 1);
    @(posedge clock);
  endtask

  task automatic collect(input int d, input bit ack_tied);
    int n;
    int bad;
    bit got;
    n = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n++;
      ack = ack_tied;
      start = (n <= 2 + 2 * d) ? 1'($urandom_range(0, 1)) : 1'b0;
      degree = 3'($urandom_range(0, 7));
      if (n == 1) chk("load_x_after_accept", load_x, 1);
      if (valid) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    chk("latency", got ? n : -1, 3 + 2 * d);
    chk("err_low", err, 0);
    chk("result", acc, exp_res);
    chk("load_x_pulses", nx - base_nx, 1);
    chk("load_acc_pulses", nacc - base_nacc, 1 + 2 * d);
    bad = 0;
    if (seqq.size() - base_seq != 1 + 2 * d) bad++;
    else begin
      if (seqq[base_seq] != d) bad++;
      for (int k = 0; k < d; k++) begin
        if (seqq[base_seq + 1 + 2 * k] / 16 != 1) bad++;
        if (seqq[base_seq + 2 + 2 * k] != 2 * 16 + (d - 1 - k)) bad++;
      end
    end
    chk("acc_sequence_errors", bad, 0);
  endtask

  task automatic release_op(input int hold, input bit ack_tied);
    if (!ack_tied) begin
      for (int i = 0; i < hold; i++) begin
        start = 1'($urandom_range(0, 1));
        degree = 3'($urandom_range(0, 7));
        #1 chk("ready_low_in_done", ready, 0);
        @(posedge clock);
        @(negedge clock);
        chk("valid_held", valid, 1);
      end
      start = 1'b0;
      ack = 1'b1;
    end
    #1 chk("ready_on_ack", ready, 1);
    @(posedge clock);
    @(negedge clock);
    ack = 1'b0;
    chk("valid_after_ack", valid, 0);
    chk("ready_after_ack", ready, 1);
    chk("no_extra_load_x", nx - base_nx, 1);
  endtask

  initial begin
    int vcount;
    start = 0; ack = 0; degree = 0;
    start5 = 0; ack5 = 0; degree5 = 0;
    rand_en = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_load_x", load_x, 0);
    chk("rst_load_acc", load_acc, 0);
    chk("rst_sel_acc", sel_acc, 0);
    chk("rst_coef_idx", coef_idx, 0);
    chk("rst5_ready", ready5, 1);
    chk("rst5_valid", valid5, 0);

    // degree 2, ack tied high, x=3, a=[1,2,5]
    @(negedge clock);
    rand_en = 0;
    coef[0] = 1; coef[1] = 2; coef[2] = 5; xin = 3;
    issue(2);
    collect(2, 1);
    chk("result_52", acc, 52);
    release_op(0, 1);

    // degree 0, x=9, a0=4
    coef[0] = 4; xin = 9;
    issue(0);
    collect(0, 1);
    chk("result_4", acc, 4);
    release_op(0, 1);
    rand_en = 1;

    // degree 7, ack held low for 5 cycles
    issue(7);
    collect(7, 0);
    release_op(5, 0);

    // back-to-back: accept degree 1 in DONE with ack
    issue(3);
    collect(3, 0);
    ack = 1'b1;
    issue(1);
    collect(1, 0);
    release_op(2, 0);

    // reset during an ADD cycle of a degree-4 operation
    issue(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("in_add_sel", sel_acc, 2);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_valid", valid, 0);
    chk("abort_load_x", load_x, 0);
    chk("abort_load_acc", load_acc, 0);
    chk("abort_coef_idx", coef_idx, 0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (valid) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    issue(1);
    collect(1, 0);
    release_op(0, 0);

    // MAX_DEG=5 instance, out-of-range degrees
    for (int k = 6; k <= 7; k++) begin
      start5 = 1'b1;
      degree5 = 3'(k);
      #1 chk("ready5_at_start", ready5, 1);
      @(posedge clock);
      @(negedge clock);
      start5 = 1'b0;
      chk("err5_valid", valid5, 1);
      chk("err5_err", err5, 1);
      @(posedge clock);
      @(negedge clock);
      chk("err5_valid_held", valid5, 1);
      ack5 = 1'b1;
      #1 chk("ready5_on_ack", ready5, 1);
      @(posedge clock);
      @(negedge clock);
      ack5 = 1'b0;
      chk("err5_valid_cleared", valid5, 0);
      chk("err5_err_cleared", err5, 0);
    end
    chk("err5_no_load_x", nx5, 0);
    chk("err5_no_load_acc", nacc5, 0);

    // randomized operations
    for (int r = 0; r < 10; r++) begin
      int d;
      bit tied;
      d = $urandom_range(0, 7);
      tied = 1'($urandom_range(0, 1));
      issue(d);
      collect(d, tied);
      release_op($urandom_range(0, 3), tied);
    end

    chk("idle_index_or_select_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
